// File: rtl/exp2_scale_if.sv
// Stream bundle for exp2_scale: integer exponent in, aligned mantissa in,
// scaled float out, plus status counters.
interface exp2_scale_if #(
  parameter int BITS  = 16,
  parameter int IBITS = 8
);
  logic                    in_valid;
  logic signed [IBITS-1:0] ipart;
  logic [BITS-1:0]         mant_in;
  logic                    clr_status;
  logic                    out_valid;
  logic [BITS-1:0]         x;
  logic                    ovf;
  logic                    unf;
  logic [7:0]              ovf_count;
  logic [7:0]              unf_count;

  modport master (
    output in_valid, ipart, mant_in, clr_status,
    input  out_valid, x, ovf, unf, ovf_count, unf_count
  );

  modport slave (
    input  in_valid, ipart, mant_in, clr_status,
    output out_valid, x, ovf, unf, ovf_count, unf_count
  );
endinterface

// File: rtl/exp2_scale.sv
// Final exp2 stage: scales the upstream 2^fpart mantissa by 2^ipart through
// direct exponent arithmetic, saturating to inf or flushing to zero.
module exp2_scale #(
  parameter int    BITS        = 16,
  parameter string PRECISION   = "HALF",
  parameter int    ALIGN_DELAY = 20,
  parameter int    IBITS       = 8
) (
  input logic       clk,
  input logic       rst,
  exp2_scale_if.slave bus
);
  localparam int EW   = (PRECISION == "SINGLE") ? 8 : 5;
  localparam int MW   = BITS - 1 - EW;
  localparam int EXTW = ((IBITS > EW) ? IBITS : EW) + 2;
  localparam logic signed [EXTW-1:0] EXP_MAX  = EXTW'((2 ** EW) - 1);
  localparam logic signed [EXTW-1:0] EXP_ZERO = '0;

  logic [ALIGN_DELAY-1:0] dvld_q;
  logic [IBITS-1:0]       dip_q [ALIGN_DELAY];
  logic                   s1_vld_q;
  logic [BITS-1:0]        s1_mant_q;
  logic [IBITS-1:0]       s1_ip_q;
  logic                   out_valid_q, out_valid_d;
  logic [BITS-1:0]        x_q, x_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic [7:0]             ovf_cnt_q, ovf_cnt_d;
  logic [7:0]             unf_cnt_q, unf_cnt_d;

  // Valid path of the alignment line: cleared on reset so in-flight
  // samples are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvld_q   <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage shift on the same
      // edge regardless of statement order.
      dvld_q[0] <= bus.in_valid;
      for (int i = 1; i < ALIGN_DELAY; i++) dvld_q[i] <= dvld_q[i-1];
      s1_vld_q <= dvld_q[ALIGN_DELAY-1];
    end
  end

  // NOTE: data registers carry no reset; their contents only matter when the
  // matching valid bit is set, and leaving them out keeps the line a plain
  // shift register.
  always_ff @(posedge clk) begin
    dip_q[0] <= bus.ipart;
    for (int i = 1; i < ALIGN_DELAY; i++) dip_q[i] <= dip_q[i-1];
    s1_ip_q   <= dip_q[ALIGN_DELAY-1];
    s1_mant_q <= bus.mant_in;
  end

  logic [EW-1:0]          exp_f;
  logic                   sign_f;
  logic signed [EXTW-1:0] e_new;

  assign exp_f  = s1_mant_q[BITS-2 -: EW];
  assign sign_f = s1_mant_q[BITS-1];
  assign e_new  = $signed({{(EXTW-EW){1'b0}}, exp_f})
                + $signed({{(EXTW-IBITS){s1_ip_q[IBITS-1]}}, s1_ip_q});

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    out_valid_d = s1_vld_q;
    x_d         = '0;
    ovf_d       = 1'b0;
    unf_d       = 1'b0;
    if (s1_vld_q) begin
      if (exp_f == '1) begin
        x_d = s1_mant_q;
      end else if (exp_f == '0) begin
        x_d = {sign_f, {(BITS-1){1'b0}}};
      end else if (e_new >= EXP_MAX) begin
        x_d   = {sign_f, {EW{1'b1}}, {MW{1'b0}}};
        ovf_d = 1'b1;
      end else if (e_new <= EXP_ZERO) begin
        x_d   = {sign_f, {(BITS-1){1'b0}}};
        unf_d = 1'b1;
      end else begin
        x_d = {sign_f, e_new[EW-1:0], s1_mant_q[MW-1:0]};
      end
    end
  end

  // Counters look at the registered result, so clr_status always wins
  // over an event arriving on the same edge.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;
    if (bus.clr_status) begin
      ovf_cnt_d = '0;
      unf_cnt_d = '0;
    end else begin
      if (out_valid_q && ovf_q && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
      if (out_valid_q && unf_q && (unf_cnt_q != 8'hFF)) unf_cnt_d = unf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      x_q         <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      ovf_cnt_q   <= '0;
      unf_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      ovf_cnt_q   <= ovf_cnt_d;
      unf_cnt_q   <= unf_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
  assign bus.ovf_count = ovf_cnt_q;
  assign bus.unf_count = unf_cnt_q;
endmodule

// File: tb/tb_exp2_scale.sv
// Directed bench for exp2_scale (HALF precision): a cycle-indexed plan of
// stimulus and expected results, checked against the DUT every cycle.
module tb_exp2_scale;
  localparam int D  = 20;
  localparam int NC = 700;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exp2_scale_if #(.BITS(16), .IBITS(8)) bus ();

  exp2_scale #(
    .BITS(16), .PRECISION("HALF"), .ALIGN_DELAY(D), .IBITS(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus plan, indexed by cycle
  logic              st_v   [NC];
  logic signed [7:0] st_ip  [NC];
  logic [15:0]       st_m   [NC];
  logic              st_clr [NC];
  logic              st_rst [NC];
  // Expected outputs, indexed by cycle
  logic              exv [NC];
  logic [15:0]       exx [NC];
  logic              exo [NC];
  logic              exu [NC];
  // Hand-computed literal pins: kind 0 = x, 1 = ovf_count, 2 = unf_count
  int                lit_c [16];
  int                lit_k [16];
  logic [15:0]       lit_v [16];
  int                lit_n = 0;

  int checks = 0;
  int failures = 0;
  int cyc = -1;
  int w = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, req);
    end
  endtask

  // Reference behaviour in integer arithmetic: returns {ovf, unf, x}
  function automatic logic [17:0] model(input logic [15:0] m, input int n);
    int e, ne;
    e = int'(m[14:10]);
    if (e == 31) return {2'b00, m};
    if (e == 0)  return {2'b00, m[15], 15'h0};
    ne = e + n;
    if (ne >= 31) return {2'b10, m[15], 5'h1F, 10'h0};
    if (ne <= 0)  return {2'b01, m[15], 15'h0};
    return {2'b00, m[15], 5'(ne), m[9:0]};
  endfunction

  task automatic push(input logic [15:0] m, input int n);
    logic [17:0] r;
    r = model(m, n);
    st_v[w]      = 1'b1;
    st_ip[w]     = 8'(n);
    st_m[w+D]    = m;
    exv[w+D+2]   = 1'b1;
    exo[w+D+2]   = r[17];
    exu[w+D+2]   = r[16];
    exx[w+D+2]   = r[15:0];
    w++;
  endtask

  task automatic pin(input int c, input int k, input logic [15:0] v);
    lit_c[lit_n] = c;
    lit_k[lit_n] = k;
    lit_v[lit_n] = v;
    lit_n++;
  endtask

  task automatic do_reset(input int len);
    for (int i = w + 1; i <= w + D + 3; i++) begin
      exv[i] = 1'b0; exx[i] = '0; exo[i] = 1'b0; exu[i] = 1'b0;
    end
    for (int i = 0; i < len; i++) st_rst[w+i] = 1'b1;
    w += len;
  endtask

  initial begin
    int cnt_o, cnt_u, t;
    rst = 1'b1;
    bus.in_valid   = 1'b0;
    bus.ipart      = '0;
    bus.mant_in    = '0;
    bus.clr_status = 1'b0;
    for (int i = 0; i < NC; i++) begin
      st_v[i] = 1'b0; st_ip[i] = 8'(i * 7); st_m[i] = 16'h5A5A ^ 16'(i * 37);
      st_clr[i] = 1'b0; st_rst[i] = 1'b0;
      exv[i] = 1'b0; exx[i] = '0; exo[i] = 1'b0; exu[i] = 1'b0;
    end

    // Pin the model to hand-derived values
    check("model_scale_up", 32'(model(16'h3C00, 3)),   32'h0_4800);
    check("model_ovf",      32'(model(16'h3C00, 16)),  32'h2_7C00);
    check("model_unf",      32'(model(16'h3E00, -15)), 32'h1_0000);
    check("model_nan",      32'(model(16'h7E00, -4)),  32'h0_7E00);
    check("model_frac",     32'(model(16'h3555, -10)), 32'h0_0D55);

    // Basic scale and latency
    t = w + D + 2;
    push(16'h3C00, 3);
    pin(t, 0, 16'h4800);
    pin(t, 1, 16'h0000);
    w += 5;
    // Boundary mix
    t = w + D + 2;
    push(16'h3C00, 16);   pin(t, 0, 16'h7C00); pin(t + 1, 1, 16'h0001);
    push(16'h3E00, -15);  pin(t + 1, 0, 16'h0000);
    push(16'h7E00, -4);   pin(t + 2, 0, 16'h7E00);
    push(16'h8000, 5);    pin(t + 3, 0, 16'h8000);
    push(16'hBC00, 3);
    push(16'h0001, 4);
    push(16'h7BFF, 1);
    push(16'h0400, -1);
    push(16'h0400, 0);
    push(16'h3555, -10);
    push(16'hC000, 127);
    push(16'h4000, -128);
    push(16'hFC00, -3);
    push(16'h3800, 14);
    w += D + 5;
    // Saturation of the overflow counter
    for (int i = 0; i < 300; i++) push(16'h3C00, 16);
    pin(w + D + 2, 1, 16'h00FF);
    w += 4;
    // Clear coincident with an overflow result
    push(16'h3C00, 16);
    st_clr[w - 1 + D + 2] = 1'b1;
    pin(w + D + 2, 1, 16'h0000);
    w += D + 5;
    // Reset in the middle of a stream
    for (int i = 0; i < 5; i++) push(16'h3C00 + 16'(i * 64), i - 2);
    do_reset(3);
    w += 2;
    t = w + D + 2;
    for (int i = 0; i < 5; i++) push(16'hC200 + 16'(i * 64), 2 - i);
    pin(t, 0, 16'hCA00);
    pin(t + D + 6, 2, 16'h0000);
    w += D + 8;
    if (w >= NC) $fatal(1, "FAIL plan_overflow cycle=%0d got=%0d expected<%0d", w, w, NC);

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_x",         32'(bus.x),         32'h0);
    check("rst_ovf_count", 32'(bus.ovf_count), 32'h0);
    check("rst_unf_count", 32'(bus.unf_count), 32'h0);
    rst = 1'b0;

    cnt_o = 0;
    cnt_u = 0;
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      cyc = c;
      check("out_valid", 32'(bus.out_valid), 32'(exv[c]));
      check("x",         32'(bus.x),         32'(exx[c]));
      check("ovf",       32'(bus.ovf),       32'(exo[c]));
      check("unf",       32'(bus.unf),       32'(exu[c]));
      check("ovf_count", 32'(bus.ovf_count), 32'(cnt_o));
      check("unf_count", 32'(bus.unf_count), 32'(cnt_u));
      for (int k = 0; k < lit_n; k++) begin
        if (lit_c[k] == c) begin
          case (lit_k[k])
            0:       check("pin_x",         32'(bus.x),         32'(lit_v[k]));
            1:       check("pin_ovf_count", 32'(bus.ovf_count), 32'(lit_v[k]));
            default: check("pin_unf_count", 32'(bus.unf_count), 32'(lit_v[k]));
          endcase
        end
      end
      if (st_rst[c] || st_clr[c]) begin
        cnt_o = 0;
        cnt_u = 0;
      end else begin
        if (exv[c] && exo[c] && cnt_o < 255) cnt_o++;
        if (exv[c] && exu[c] && cnt_u < 255) cnt_u++;
      end

      bus.in_valid   = st_v[c];
      bus.ipart      = st_ip[c];
      bus.mant_in    = st_m[c];
      bus.clr_status = st_clr[c];
      if (st_rst[c]) begin
        if (!rst) begin
          rst = 1'b1;
          #1;
          check("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
          check("async_rst_x",         32'(bus.x),         32'h0);
          check("async_rst_ovf_count", 32'(bus.ovf_count), 32'h0);
        end
      end else begin
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exp2_scale.md
EXP2_SCALE -- requirements
Module: exp2_scale

Interface
REQ-001 Parameter BITS, default 16, floating-point word width; only 16 and 32 legal.
REQ-002 Parameter PRECISION, default "HALF", "HALF" (5-bit exponent, bias 15) or "SINGLE" (8-bit exponent, bias 127); must match BITS.
REQ-003 Parameter ALIGN_DELAY, default 20, cycles between ipart acceptance and the matching mant_in appearing; legal range 1..64.
REQ-004 Parameter IBITS, default 8, width of the two's-complement integer exponent.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  qualifies ipart for the current cycle.
REQ-008 ipart  input  IBITS  signed integer part n of the exp2 argument.
REQ-009 mant_in  input  BITS  2^fpart result from the upstream Pade stage, free-running, no valid.
REQ-010 clr_status  input  1  synchronous clear of status counters.
REQ-011 out_valid  output  1  qualifies x.
REQ-012 x  output  BITS  mant_in * 2^ipart.
REQ-013 ovf  output  1  x for this output saturated to +/-inf.
REQ-014 unf  output  1  x for this output flushed to zero.
REQ-015 ovf_count, unf_count  output  8 each  saturating event counters.

Function
REQ-016 The block shall carry in_valid and ipart through an ALIGN_DELAY-deep shift register; one entry per cycle, no backpressure, every cycle accepted.
REQ-017 At delayed-valid cycle k, the block shall sample mant_in into stage 1 together with the delayed ipart.
REQ-018 Stage 2 shall compute e_new = exponent(mant_in) + sign-extended ipart at width max(IBITS, exponent width)+2, no wraparound.
REQ-019 Stage 3 shall register x, ovf, unf, out_valid; latency from delayed valid to out_valid = 2 cycles; total latency from in_valid = ALIGN_DELAY+2.
REQ-020 If mant_in exponent field is all ones (inf/NaN), x shall equal mant_in unchanged, ovf=unf=0.
REQ-021 If mant_in exponent field is zero (zero/subnormal), x shall be signed zero, ovf=unf=0.
REQ-022 Else if e_new >= all-ones exponent, x shall be signed infinity (HALF 0x7C00/0xFC00), ovf=1.
REQ-023 Else if e_new <= 0, x shall be signed zero (no subnormal output), unf=1.
REQ-024 Else x shall be mant_in with exponent field replaced by e_new, sign and mantissa unchanged.
REQ-025 ovf and unf shall be mutually exclusive and valid only with out_valid; when out_valid=0, x, ovf, unf shall hold 0.
REQ-026 Counters shall increment by one per out_valid cycle with ovf (resp. unf) set, saturating at 255.
REQ-027 clr_status has priority: a counter event coincident with clr_status is discarded; counters read 0 next cycle.
REQ-028 Back-to-back in_valid shall produce back-to-back out_valid, one result per cycle, in order.

Reset
REQ-029 On rst assertion, all delay-line valids, out_valid, x, ovf, unf, ovf_count, unf_count shall go to 0 immediately.
REQ-030 In-flight samples at reset shall be discarded; no out_valid until ALIGN_DELAY+2 cycles after the first post-reset in_valid.
REQ-031 ipart/mant data registers need not reset; only valid paths and outputs are required to.

Verification
REQ-032 HALF, ipart=3, mant_in=0x3C00 at delayed cycle -> x=0x4800, ovf=unf=0, out_valid exactly ALIGN_DELAY+2 cycles after in_valid.
REQ-033 ipart=16, mant_in=0x3C00 -> x=0x7C00, ovf=1, ovf_count increments 0->1; ipart=-15, mant_in=0x3E00 -> x=0x0000, unf=1.
REQ-034 mant_in=0x7E00 (NaN) with ipart=-4 -> x=0x7E00, no flags; mant_in=0x8000 -> x=0x8000.
REQ-035 300 consecutive overflow samples -> ovf_count stops at 255; clr_status asserted with an overflow sample -> count reads 0.
REQ-036 Stream of 10 in_valid, rst pulsed after 5 -> no out_valid for discarded samples, outputs 0 during and after reset, fresh stream after release matches golden model.
